// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encodings, BYPASS opcode helper and the
// 1149.1 TMS transition graph.
package tap_pkg;

   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SH_DR    = 4'h2,
      EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3,
      EX2_DR   = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SH_IR    = 4'hA,
      EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB,
      EX2_IR   = 4'h8,
      UPD_IR   = 4'hD
   } tap_state_e;

   typedef enum logic [1:0] {
      DR_BYPASS = 2'd0,
      DR_IDCODE = 2'd1,
      DR_USER   = 2'd2
   } dr_sel_e;

   localparam int unsigned IDCODE_W = 32;

   // All-ones opcode of the given IR width (widths up to 32 bits).
   function automatic logic [31:0] bypass_opcode(input int unsigned ir_w);
      if (ir_w >= 32)
         return '1;
      return (32'd1 << ir_w) - 32'd1;
   endfunction

   // Standard TMS graph; unreachable codes do not exist since all 16 are used.
   function automatic tap_state_e next_state(input tap_state_e state, input logic tms);
      case (state)
         TLR:      return tms ? TLR      : RTI;
         RTI:      return tms ? SEL_DR   : RTI;
         SEL_DR:   return tms ? SEL_IR   : CAP_DR;
         CAP_DR:   return tms ? EX1_DR   : SH_DR;
         SH_DR:    return tms ? EX1_DR   : SH_DR;
         EX1_DR:   return tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: return tms ? EX2_DR   : PAUSE_DR;
         EX2_DR:   return tms ? UPD_DR   : SH_DR;
         UPD_DR:   return tms ? SEL_DR   : RTI;
         SEL_IR:   return tms ? TLR      : CAP_IR;
         CAP_IR:   return tms ? EX1_IR   : SH_IR;
         SH_IR:    return tms ? EX1_IR   : SH_IR;
         EX1_IR:   return tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: return tms ? EX2_IR   : PAUSE_IR;
         EX2_IR:   return tms ? UPD_IR   : SH_IR;
         UPD_IR:   return tms ? SEL_DR   : RTI;
         default:  return TLR;
      endcase
   endfunction

endpackage

// File: rtl/tap_fsm.sv
// TAP state machine: state register plus TMS-driven transition logic.
// Also exports the next state so datapath updates can coincide with entry.
module tap_fsm
   import tap_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tms,
   output tap_state_e state,
   output tap_state_e state_nxt
);

   // Next state, with reset forcing Test-Logic-Reset regardless of TMS.
   always_comb begin
      state_nxt = TLR;
      if (!rst)
         state_nxt = next_state(state, tms);
   end

   // State register.
   always_ff @(posedge clk) begin
      state <= state_nxt;
   end

endmodule

// File: rtl/tap_ctrl_ir.sv
// TAP controller with instruction register, BYPASS, IDCODE and a user data
// register, plus the serial TDI/TDO scan path.
module tap_ctrl_ir
   import tap_pkg::*;
#(
   parameter int unsigned     IR_W       = 4,
   parameter int unsigned     DR_W       = 8,
   parameter logic [31:0]     IDCODE_VAL = 32'h1234_5671,
   parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(1),
   parameter logic [IR_W-1:0] OP_USER    = IR_W'(2)
) (
   input  logic            GCLK_Pad,
   input  logic            TRST_Pad,
   input  logic            TMS_Pad,
   input  logic            TDI_Pad,
   output logic            TDO_Pad,
   output logic [3:0]      state_obs_Pad,
   output logic [IR_W-1:0] ir_obs,
   input  logic [DR_W-1:0] user_dr_in,
   output logic [DR_W-1:0] user_dr_out,
   output logic            user_update
);

   localparam logic [31:0]     BYP_FULL  = bypass_opcode(IR_W);
   localparam logic [IR_W-1:0] OP_BYPASS = BYP_FULL[IR_W-1:0];

   tap_state_e state;
   tap_state_e state_nxt;

   logic [IR_W-1:0]     ir_sr;
   logic [IR_W-1:0]     ir_q;
   logic [IDCODE_W-1:0] id_sr;
   logic [DR_W-1:0]     user_sr;
   logic [DR_W-1:0]     user_q;
   logic                byp_sr;
   dr_sel_e             dr_sel;

   tap_fsm u_fsm (
      .clk       (GCLK_Pad),
      .rst       (TRST_Pad),
      .tms       (TMS_Pad),
      .state     (state),
      .state_nxt (state_nxt)
   );

   // Data register selection from the active instruction; unknown codes bypass.
   always_comb begin
      dr_sel = DR_BYPASS;
      if (ir_q == OP_BYPASS)
         dr_sel = DR_BYPASS;
      else if (ir_q == OP_IDCODE)
         dr_sel = DR_IDCODE;
      else if (ir_q == OP_USER)
         dr_sel = DR_USER;
   end

   // IR capture/shift and update; updates land on the edge entering UpdIR/TLR.
   always_ff @(posedge GCLK_Pad) begin
      if (TRST_Pad) begin
         ir_sr <= '0;
         ir_q  <= OP_IDCODE;
      end else begin
         if (state == CAP_IR)
            ir_sr <= IR_W'(1);
         else if (state == SH_IR)
            ir_sr <= {TDI_Pad, ir_sr[IR_W-1:1]};

         if (state_nxt == TLR)
            ir_q <= OP_IDCODE;
         else if (state_nxt == UPD_IR)
            ir_q <= ir_sr;
      end
   end

   // DR capture/shift of the selected register and USER update on UpdDR entry.
   always_ff @(posedge GCLK_Pad) begin
      if (TRST_Pad) begin
         id_sr   <= '0;
         user_sr <= '0;
         byp_sr  <= 1'b0;
         user_q  <= '0;
      end else begin
         if (state == CAP_DR) begin
            case (dr_sel)
               DR_IDCODE: id_sr   <= IDCODE_VAL;
               DR_USER:   user_sr <= user_dr_in;
               default:   byp_sr  <= 1'b0;
            endcase
         end else if (state == SH_DR) begin
            case (dr_sel)
               DR_IDCODE: id_sr   <= {TDI_Pad, id_sr[IDCODE_W-1:1]};
               // Shift form that stays legal for a one-bit user register.
               DR_USER:   user_sr <= (user_sr >> 1) | (DR_W'(TDI_Pad) << (DR_W - 1));
               default:   byp_sr  <= TDI_Pad;
            endcase
         end

         if (state_nxt == UPD_DR && dr_sel == DR_USER)
            user_q <= user_sr;
      end
   end

   // Serial output: LSB of the register being shifted, else low.
   always_comb begin
      TDO_Pad = 1'b0;
      if (state == SH_IR) begin
         TDO_Pad = ir_sr[0];
      end else if (state == SH_DR) begin
         case (dr_sel)
            DR_IDCODE: TDO_Pad = id_sr[0];
            DR_USER:   TDO_Pad = user_sr[0];
            default:   TDO_Pad = byp_sr;
         endcase
      end
   end

   // Observation outputs; the update pulse spans exactly the UpdDR cycle.
   always_comb begin
      state_obs_Pad = state;
      ir_obs        = ir_q;
      user_dr_out   = user_q;
      user_update   = (state == UPD_DR) && (dr_sel == DR_USER);
   end

endmodule

// File: doc/tap_ctrl_ir.md
# tap_ctrl_ir

Parametrised IEEE 1149.1-style TAP controller. It extends the state-only TAP router with an instruction register, BYPASS, IDCODE and a user data register, plus a serial TDI/TDO path. It sits at the chip pad boundary, is driven by the global test clock, and exposes its 4-bit state on observation pads for debug.

## Interface
Parameters:
- IR_W, 4: instruction register width (≥2).
- DR_W, 8: user data register width (≥1).
- IDCODE_VAL, 32'h1234_5671: IDCODE value; bit 0 must be 1.
- OP_IDCODE, 1: IDCODE opcode.
- OP_USER, 2: USER opcode.
- BYPASS opcode is fixed at all ones.

Ports:
- GCLK_Pad in 1: test clock; all state changes on the rising edge.
- TRST_Pad in 1: reset; synchronous, active-high.
- TMS_Pad in 1: mode select, sampled on the rising edge.
- TDI_Pad in 1: serial data in, sampled on the rising edge.
- TDO_Pad out 1: serial data out.
- state_obs_Pad out 4: current TAP state encoding.
- ir_obs out IR_W: current (updated) instruction.
- user_dr_in in DR_W: parallel capture value for USER.
- user_dr_out out DR_W: USER update register.
- user_update out 1: one-cycle pulse when USER is updated.

## Operation
State encoding:
- TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D

Transitions are the standard 1149.1 TMS graph. Summary (TMS=1 / TMS=0):
- TLR: TLR / RTI
- RTI: SelDR / RTI
- SelDR: SelIR / CapDR
- SelIR: TLR / CapIR
- Cap: Ex1 / Sh
- Sh: Ex1 / Sh
- Ex1: Upd / Pause
- Pause: Ex2 / Pause
- Ex2: Upd / Sh
- Upd: SelDR / RTI

IR path:
- CapIR loads the IR shift register with {0…0,1}.
- ShIR shifts right: TDI enters the MSB, the LSB goes out.
- UpdIR copies the shift register to ir_obs.
- TLR forces ir_obs=OP_IDCODE.

DR selection is by ir_obs:
- OP_IDCODE: 32-bit register.
- OP_USER: DR_W-bit register.
- All other codes, including all ones: 1-bit BYPASS register.

DR path:
- CapDR loads IDCODE_VAL, user_dr_in, or 0 for BYPASS.
- ShDR shifts right, same direction as the IR path.
- UpdDR with USER selected: user_dr_out ← shift register, and user_update=1 for exactly that cycle.
- UpdDR has no side effect for IDCODE or BYPASS.

TDO_Pad is combinational:
- In ShIR or ShDR, it is the LSB of the selected shift register.
- Otherwise it is 0.

## Timing
- Reset (TRST_Pad=1 at an edge): state=TLR, ir_obs=OP_IDCODE, user_dr_out=0, user_update=0, shift registers=0, TDO_Pad=0 from the next cycle. TRST_Pad overrides TMS_Pad when both are high.
- Reset mid-scan aborts the scan. No Update occurs and user_dr_out keeps 0.
- Five consecutive TMS=1 edges reach TLR from any state.
- state_obs_Pad reflects the registered state: one-edge latency from TMS.
- First-shift ordering: the first TDO bit is valid in the first cycle of Sh, before the first Sh edge. Each Sh edge shifts one bit.
- The Ex1 transition edge also shifts, as in standard 1149.1. N bits take N edges with TMS=1 on the Nth.
- user_update is asserted in the cycle state=UpdDR and deasserts on the next edge.
- Capture-to-TDO latency is 0 cycles after entering Sh.
- BYPASS adds exactly one cycle of delay TDI→TDO.

## Structure
- Package tap_pkg holds:
  - the tap_state_e enum with the 16 encodings above;
  - the BYPASS-opcode function (all ones of IR_W);
  - the next-state function next_state(state, tms).
- Sub-module tap_fsm holds the state register and transition logic, and outputs the state. tap_ctrl_ir instantiates it and holds the IR and DR registers.

## Test plan
- Reset: TRST_Pad=1 on one edge from any state → state_obs_Pad=F, ir_obs=1, TDO_Pad=0. Then TMS=0 for one edge → state C.
- IDCODE read: after reset, TMS 0,1,0,0 → state 2. Shift 32 bits with TDI=0 and TMS=1 on the last → TDO LSB-first gives 32'h1234_5671. Then TMS 1,0 → UpdDR→RTI.
- IR load:
  - From RTI, TMS 1,1,0,0 → ShIR (A). Shift 4'h2 LSB-first → TDO reads 0b0001 LSB-first.
  - Then TMS 1,0 → ir_obs=2.
- USER scan: user_dr_in=8'h3C. DR scan shifting in 8'hA5 → TDO reads 8'h3C LSB-first. At UpdDR, user_dr_out=8'hA5 and user_update is high for exactly 1 cycle.
- BYPASS: load IR=4'hF, then shift TDI pattern 1,0,1,1 → TDO shows 0,1,0,1 (one-cycle delay, captured 0 first). An undefined opcode 4'h7 behaves identically.
- Abort: mid-ShDR of a USER scan, assert TRST_Pad=1 → state=F, user_update never pulses, user_dr_out=8'h00.
